// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RISC-V style control FSM: fetch, decode, execute, memory and
// writeback sequencing with bounded handshake waits and a sticky trap state.
module mc_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 15,
   parameter bit SUPPORT_M   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [6:0] funct7,
   input  logic       mem_ready,
   input  logic       alu_done,
   output logic       imem_req,
   output logic       ir_en,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic       alu_start,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [2:0] mem_to_reg,
   output logic [1:0] branch,
   output logic       pc_en,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [2:0] state_out
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
   localparam logic [1:0] CAUSE_FETCH   = 2'b01;
   localparam logic [1:0] CAUSE_DATA    = 2'b10;
   localparam logic [1:0] CAUSE_ALU     = 2'b11;

   // Counter just wide enough to hold MEM_TIMEOUT; it saturates so that with
   // timeouts disabled it never wraps back to the "first cycle" value.
   localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t         state;
   logic [CW-1:0]  wait_cnt;
   logic [CW-1:0]  wait_cnt_inc;
   logic           timeout_hit;
   logic           is_mop;
   logic           mop_en;
   logic           legal_op;

   assign wait_cnt_inc = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
   assign timeout_hit  = (MEM_TIMEOUT != 0) && (wait_cnt == CW'(MEM_TIMEOUT));
   assign is_mop       = (opcode == OP_R) && (funct7 == F7_MULDIV);
   assign mop_en       = is_mop && SUPPORT_M;
   assign legal_op     = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
                                        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
   assign state_out    = state;

   // State, wait counter and trap cause; every state change clears the counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         state      <= S_FETCH;
         wait_cnt   <= '0;
         trap_cause <= CAUSE_ILLEGAL;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  state    <= S_DECODE;
                  wait_cnt <= '0;
               end else if (timeout_hit) begin
                  state      <= S_TRAP;
                  trap_cause <= CAUSE_FETCH;
                  wait_cnt   <= '0;
               end else begin
                  wait_cnt <= wait_cnt_inc;
               end
            end
            S_DECODE: begin
               wait_cnt <= '0;
               if (!legal_op || (is_mop && !SUPPORT_M)) begin
                  state      <= S_TRAP;
                  trap_cause <= CAUSE_ILLEGAL;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (mop_en) begin
                  if (alu_done) begin
                     state    <= S_FETCH;
                     wait_cnt <= '0;
                  end else if (timeout_hit) begin
                     state      <= S_TRAP;
                     trap_cause <= CAUSE_ALU;
                     wait_cnt   <= '0;
                  end else begin
                     wait_cnt <= wait_cnt_inc;
                  end
               end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                  state    <= S_MEM;
                  wait_cnt <= '0;
               end else begin
                  state    <= S_FETCH;
                  wait_cnt <= '0;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  state    <= (opcode == OP_LOAD) ? S_WB : S_FETCH;
                  wait_cnt <= '0;
               end else if (timeout_hit) begin
                  state      <= S_TRAP;
                  trap_cause <= CAUSE_DATA;
                  wait_cnt   <= '0;
               end else begin
                  wait_cnt <= wait_cnt_inc;
               end
            end
            S_WB: begin
               state    <= S_FETCH;
               wait_cnt <= '0;
            end
            S_TRAP: begin
               state <= S_TRAP;
            end
            default: begin
               state    <= S_FETCH;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // Control outputs decoded from the current state and instruction fields.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      imem_req   = 1'b0;
      ir_en      = 1'b0;
      alu_op     = 2'b00;
      alu_src    = 1'b0;
      alu_start  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 3'b000;
      branch     = 2'b00;
      pc_en      = 1'b0;
      trap       = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_en    = mem_ready & ~reset;
         end
         S_EXEC: begin
            case (opcode)
               OP_R: begin
                  if (mop_en) begin
                     alu_start = (wait_cnt == '0);
                     reg_write = alu_done;
                     pc_en     = alu_done;
                  end else begin
                     reg_write = 1'b1;
                     pc_en     = 1'b1;
                  end
               end
               OP_I: begin
                  alu_src   = 1'b1;
                  reg_write = 1'b1;
                  pc_en     = 1'b1;
               end
               OP_LUI: begin
                  alu_op     = 2'b11;
                  mem_to_reg = 3'b011;
                  reg_write  = 1'b1;
                  pc_en      = 1'b1;
               end
               OP_AUIPC: begin
                  alu_op     = 2'b11;
                  mem_to_reg = 3'b100;
                  reg_write  = 1'b1;
                  pc_en      = 1'b1;
               end
               OP_BR: begin
                  alu_op = 2'b10;
                  branch = 2'b01;
                  pc_en  = 1'b1;
               end
               OP_JAL: begin
                  branch     = 2'b10;
                  mem_to_reg = 3'b010;
                  reg_write  = 1'b1;
                  pc_en      = 1'b1;
               end
               OP_JALR: begin
                  branch     = 2'b11;
                  alu_op     = 2'b11;
                  mem_to_reg = 3'b010;
                  reg_write  = 1'b1;
                  pc_en      = 1'b1;
               end
               OP_LOAD, OP_STORE: begin
                  alu_op  = 2'b01;
                  alu_src = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            alu_op  = 2'b01;
            alu_src = 1'b1;
            if (opcode == OP_LOAD) begin
               mem_read = 1'b1;
            end else begin
               mem_write = 1'b1;
               pc_en     = mem_ready;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 3'b001;
            pc_en      = 1'b1;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: two instances (default parameters, and
// MEM_TIMEOUT=3 / SUPPORT_M=0) run directed and random instructions. For each
// instruction a cycle-by-cycle plan of inputs and expected outputs is built
// from the instruction class and its handshake delays, then replayed.
module tb_mc_ctrl_fsm;

   typedef struct packed {
      logic [2:0] st;
      logic       imem_req;
      logic       ir_en;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       alu_start;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [2:0] mem_to_reg;
      logic [1:0] branch;
      logic       pc_en;
      logic       trap;
      logic [1:0] trap_cause;
   } obs_t;

   typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC,
                     K_MUL, K_ILL} kind_t;

   typedef struct {
      kind_t      kind;
      logic [6:0] opc;
      logic [6:0] f7;
      int         fw;     // fetch wait cycles before mem_ready
      int         xw;     // M-op wait cycles before alu_done
      int         mw;     // data wait cycles before mem_ready
      int         abort;  // nonzero: reset after this many planned cycles
   } txn_t;

   typedef struct {
      logic mr;
      logic ad;
      obs_t e;
   } item_t;

   logic       clk = 1'b0;
   logic       reset      [2];
   logic [6:0] opcode     [2];
   logic [6:0] funct7     [2];
   logic       mem_ready  [2];
   logic       alu_done   [2];
   logic       imem_req   [2];
   logic       ir_en      [2];
   logic [1:0] alu_op     [2];
   logic       alu_src    [2];
   logic       alu_start  [2];
   logic       mem_read   [2];
   logic       mem_write  [2];
   logic       reg_write  [2];
   logic [2:0] mem_to_reg [2];
   logic [1:0] branch     [2];
   logic       pc_en      [2];
   logic       trap       [2];
   logic [1:0] trap_cause [2];
   logic [2:0] state_out  [2];

   int    n_checks = 0;
   int    n_errors = 0;
   int    txn_no   = 0;
   item_t plan[$];

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.MEM_TIMEOUT(15), .SUPPORT_M(1'b1)) dut0 (
      .clk(clk), .reset(reset[0]), .opcode(opcode[0]), .funct7(funct7[0]),
      .mem_ready(mem_ready[0]), .alu_done(alu_done[0]),
      .imem_req(imem_req[0]), .ir_en(ir_en[0]), .alu_op(alu_op[0]),
      .alu_src(alu_src[0]), .alu_start(alu_start[0]), .mem_read(mem_read[0]),
      .mem_write(mem_write[0]), .reg_write(reg_write[0]),
      .mem_to_reg(mem_to_reg[0]), .branch(branch[0]), .pc_en(pc_en[0]),
      .trap(trap[0]), .trap_cause(trap_cause[0]), .state_out(state_out[0]));

   mc_ctrl_fsm #(.MEM_TIMEOUT(3), .SUPPORT_M(1'b0)) dut1 (
      .clk(clk), .reset(reset[1]), .opcode(opcode[1]), .funct7(funct7[1]),
      .mem_ready(mem_ready[1]), .alu_done(alu_done[1]),
      .imem_req(imem_req[1]), .ir_en(ir_en[1]), .alu_op(alu_op[1]),
      .alu_src(alu_src[1]), .alu_start(alu_start[1]), .mem_read(mem_read[1]),
      .mem_write(mem_write[1]), .reg_write(reg_write[1]),
      .mem_to_reg(mem_to_reg[1]), .branch(branch[1]), .pc_en(pc_en[1]),
      .trap(trap[1]), .trap_cause(trap_cause[1]), .state_out(state_out[1]));

   function automatic int mt_of(int d);
      return (d == 0) ? 15 : 3;
   endfunction

   function automatic bit sm_of(int d);
      return (d == 0);
   endfunction

   task automatic check(string tag, obs_t got, obs_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (st got %0d exp %0d)",
                  tag, got, exp, got.st, exp.st);
      end
   endtask

   function automatic obs_t get_obs(int d);
      obs_t o;
      o.st = state_out[d];       o.imem_req = imem_req[d];
      o.ir_en = ir_en[d];        o.alu_op = alu_op[d];
      o.alu_src = alu_src[d];    o.alu_start = alu_start[d];
      o.mem_read = mem_read[d];  o.mem_write = mem_write[d];
      o.reg_write = reg_write[d]; o.mem_to_reg = mem_to_reg[d];
      o.branch = branch[d];      o.pc_en = pc_en[d];
      o.trap = trap[d];          o.trap_cause = trap_cause[d];
      return o;
   endfunction

   function automatic obs_t blank(int st);
      obs_t o = '0;
      o.st = 3'(st);
      return o;
   endfunction

   function automatic bit is_legal(logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                        7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                        7'b0010111};
   endfunction

   function automatic logic rnd();
      return 1'($urandom);
   endfunction

   function automatic void add(logic mr, logic ad, obs_t e);
      item_t it;
      it.mr = mr;
      it.ad = ad;
      it.e  = e;
      plan.push_back(it);
   endfunction

   function automatic void add_trap(logic [1:0] cause);
      obs_t o = blank(5);
      o.trap       = 1'b1;
      o.trap_cause = cause;
      for (int i = 0; i < 3; i++) add(rnd(), rnd(), o);
   endfunction

   // One handshake wait: w idle cycles then the handshake, unless w exceeds
   // the timeout, in which case timeout+1 idle cycles and then TRAP.
   function automatic bit add_wait(int w, int mt, obs_t wait_o, obs_t hs_o,
                                   bit on_alu, logic [1:0] cause);
      bit to = (mt != 0) && (w > mt);
      int n  = to ? mt + 1 : w;
      for (int i = 0; i < n; i++) begin
         if (on_alu) add(rnd(), 1'b0, wait_o);
         else        add(1'b0, rnd(), wait_o);
      end
      if (to) begin
         add_trap(cause);
         return 1'b1;
      end
      if (on_alu) add(rnd(), 1'b1, hs_o);
      else        add(1'b1, rnd(), hs_o);
      return 1'b0;
   endfunction

   function automatic obs_t exec_single(kind_t k);
      obs_t o = blank(2);
      o.pc_en = 1'b1;
      case (k)
         K_R:     o.reg_write = 1'b1;
         K_I:     begin o.reg_write = 1'b1; o.alu_src = 1'b1; end
         K_LUI:   begin o.reg_write = 1'b1; o.alu_op = 2'b11; o.mem_to_reg = 3'b011; end
         K_AUIPC: begin o.reg_write = 1'b1; o.alu_op = 2'b11; o.mem_to_reg = 3'b100; end
         K_BR:    begin o.alu_op = 2'b10; o.branch = 2'b01; end
         K_JAL:   begin o.reg_write = 1'b1; o.branch = 2'b10; o.mem_to_reg = 3'b010; end
         K_JALR:  begin o.reg_write = 1'b1; o.branch = 2'b11; o.alu_op = 2'b11;
                        o.mem_to_reg = 3'b010; end
         default: ;
      endcase
      return o;
   endfunction

   // Builds the expected plan; returns 1 if the instruction ends in TRAP.
   function automatic bit build(int d, txn_t t);
      obs_t w_o, hs_o, o;
      int   s;
      int   mt = mt_of(d);
      plan.delete();
      w_o = blank(0);
      w_o.imem_req = 1'b1;
      hs_o = w_o;
      hs_o.ir_en = 1'b1;
      if (add_wait(t.fw, mt, w_o, hs_o, 1'b0, 2'b01)) return 1'b1;
      add(rnd(), rnd(), blank(1));
      if (t.kind == K_ILL || (t.kind == K_MUL && !sm_of(d))) begin
         add_trap(2'b00);
         return 1'b1;
      end
      case (t.kind)
         K_MUL: begin
            s = plan.size();
            w_o = blank(2);
            hs_o = blank(2);
            hs_o.reg_write = 1'b1;
            hs_o.pc_en = 1'b1;
            if (add_wait(t.xw, mt, w_o, hs_o, 1'b1, 2'b11)) begin
               plan[s].e.alu_start = 1'b1;
               return 1'b1;
            end
            plan[s].e.alu_start = 1'b1;
         end
         K_LD, K_ST: begin
            o = blank(2);
            o.alu_op = 2'b01;
            o.alu_src = 1'b1;
            add(rnd(), rnd(), o);
            w_o = blank(3);
            w_o.alu_op = 2'b01;
            w_o.alu_src = 1'b1;
            if (t.kind == K_LD) w_o.mem_read = 1'b1;
            else                w_o.mem_write = 1'b1;
            hs_o = w_o;
            if (t.kind == K_ST) hs_o.pc_en = 1'b1;
            if (add_wait(t.mw, mt, w_o, hs_o, 1'b0, 2'b10)) return 1'b1;
            if (t.kind == K_LD) begin
               o = blank(4);
               o.reg_write = 1'b1;
               o.mem_to_reg = 3'b001;
               o.pc_en = 1'b1;
               add(rnd(), rnd(), o);
            end
         end
         default: add(rnd(), rnd(), exec_single(t.kind));
      endcase
      return 1'b0;
   endfunction

   function automatic txn_t make(kind_t k, int fw, int xw, int mw);
      txn_t t;
      t.kind = k;  t.fw = fw;  t.xw = xw;  t.mw = mw;  t.abort = 0;
      t.f7 = 7'($urandom);
      case (k)
         K_R:     begin t.opc = 7'b0110011; if (t.f7 == 7'b0000001) t.f7 = 7'b0100000; end
         K_MUL:   begin t.opc = 7'b0110011; t.f7 = 7'b0000001; end
         K_I:     t.opc = 7'b0010011;
         K_LD:    t.opc = 7'b0000011;
         K_ST:    t.opc = 7'b0100011;
         K_BR:    t.opc = 7'b1100011;
         K_JAL:   t.opc = 7'b1101111;
         K_JALR:  t.opc = 7'b1100111;
         K_LUI:   t.opc = 7'b0110111;
         K_AUIPC: t.opc = 7'b0010111;
         default: begin
            t.opc = 7'b1111111;
            if (fw < 0) begin
               do t.opc = 7'($urandom); while (is_legal(t.opc));
               t.fw = 0;
            end
         end
      endcase
      return t;
   endfunction

   // Entered and left at a falling edge; the caller drives the next cycle.
   task automatic do_reset(int d);
      obs_t r = blank(0);
      r.imem_req = 1'b1;
      mem_ready[d] = 1'b1;
      alu_done[d]  = 1'b1;
      #1 reset[d] = 1'b1;
      #1 check($sformatf("reset_async d%0d", d), get_obs(d), r);
      @(negedge clk);
      check($sformatf("reset_hold d%0d", d), get_obs(d), r);
      reset[d]     = 1'b0;
      mem_ready[d] = 1'b0;
      alu_done[d]  = 1'b0;
   endtask

   task automatic run_txn(int d, txn_t t);
      bit trapped = build(d, t);
      int n = (t.abort != 0 && t.abort < plan.size()) ? t.abort : plan.size();
      txn_no++;
      opcode[d] = t.opc;
      funct7[d] = t.f7;
      for (int i = 0; i < n; i++) begin
         mem_ready[d] = plan[i].mr;
         alu_done[d]  = plan[i].ad;
         #1 check($sformatf("d%0d txn%0d op%b cyc%0d", d, txn_no, t.opc, i),
                  get_obs(d), plan[i].e);
         @(negedge clk);
      end
      if (trapped || t.abort != 0) do_reset(d);
   endtask

   function automatic txn_t rand_txn(int d);
      int   hi = (d == 0) ? 18 : 5;
      kind_t k = kind_t'($urandom_range(0, 10));
      return make(k, (k == K_ILL) ? -1 : $urandom_range(0, hi) % (hi + 1),
                  $urandom_range(0, hi), $urandom_range(0, hi));
   endfunction

   initial begin
      txn_t t;
      for (int d = 0; d < 2; d++) begin
         reset[d] = 1'b1;  opcode[d] = '0;  funct7[d] = '0;
         mem_ready[d] = 1'b0;  alu_done[d] = 1'b0;
      end
      repeat (2) @(negedge clk);

      // Default instance: directed cases first, then random instructions.
      do_reset(0);
      run_txn(0, make(K_R, 2, 0, 0));     // fetch after 2 waits
      run_txn(0, make(K_LD, 0, 0, 2));    // mem_ready in 3rd MEM cycle
      run_txn(0, make(K_MUL, 0, 5, 0));   // alu_done after 5 cycles
      run_txn(0, make(K_ILL, 0, 0, 0));   // opcode 1111111
      run_txn(0, make(K_ST, 15, 0, 15));  // handshakes exactly at the limit
      run_txn(0, make(K_MUL, 1, 15, 0));
      run_txn(0, make(K_LD, 16, 0, 0));   // fetch timeout
      run_txn(0, make(K_MUL, 0, 16, 0));  // ALU timeout
      t = make(K_ST, 0, 0, 20);           // reset in the middle of MEM
      t.abort = 5;
      run_txn(0, t);
      for (int i = 0; i < 40; i++) run_txn(0, rand_txn(0));

      // Short-timeout instance without M support.
      do_reset(1);
      run_txn(1, make(K_ST, 0, 0, 9));    // store never acknowledged
      run_txn(1, make(K_MUL, 0, 0, 0));   // MUL illegal without M support
      run_txn(1, make(K_LD, 3, 0, 3));    // both handshakes at the limit
      run_txn(1, make(K_JALR, 4, 0, 0));  // fetch timeout
      for (int i = 0; i < 40; i++) run_txn(1, rand_txn(1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
